// File: rtl/tlp_win_cap_if.sv
// tlp_win_cap_if: TLP streaming beat bundle feeding the capture window.
// The master drives beats; the capture block observes them as slave.
interface tlp_win_cap_if #(
    parameter int DATA_W = 128,
    parameter int CH_W   = 1
) ();
    logic                  st_valid;
    logic                  st_ready;
    logic                  st_sop;
    logic                  st_eop;
    logic [DATA_W/8-1:0]   st_be;
    logic [DATA_W-1:0]     st_data;
    logic [CH_W-1:0]       st_ch;

    modport master (
        output st_valid, st_ready, st_sop, st_eop, st_be, st_data, st_ch
    );

    modport slave (
        input  st_valid, st_ready, st_sop, st_eop, st_be, st_data, st_ch
    );
endinterface

// File: rtl/tlp_win_cap.sv
// tlp_win_cap: circular TLP capture buffer with header-match trigger and post-trigger count.
// Optional macro TLP_WIN_CAP_TS_EN stores a free-running 32-bit timestamp as word N+1.
module tlp_win_cap #(
    parameter int  DATA_W  = 128,
    parameter int  DEPTH_W = 10,
    parameter int  CH_W    = 1,
    localparam int NUM_CH  = 1 << CH_W,
    localparam int WSEL_W  = (DATA_W == 128) ? 3 : 2
) (
    input  logic                        trn_clk,
    input  logic                        trn_rst,
    tlp_win_cap_if.slave                st,
    input  logic                        cfg_arm,
    input  logic                        cfg_stop,
    input  logic [NUM_CH-1:0]           cfg_ch_en,
    input  logic [31:0]                 cfg_trig_mask,
    input  logic [31:0]                 cfg_trig_val,
    input  logic [DEPTH_W-1:0]          cfg_post_cnt,
    input  logic                        rd_en,
    input  logic [DEPTH_W+WSEL_W-1:0]   rd_addr,
    output logic [31:0]                 rd_data,
    output logic                        rd_valid,
    output logic [1:0]                  cap_state,
    output logic [DEPTH_W-1:0]          cap_wr_ptr,
    output logic [DEPTH_W-1:0]          cap_trig_ptr,
    output logic                        cap_wrapped
);
    localparam int N     = DATA_W / 32;
`ifdef TLP_WIN_CAP_TS_EN
    localparam int NW    = N + 2;
`else
    localparam int NW    = N + 1;
`endif
    localparam int NSEL  = 1 << WSEL_W;
    localparam int DEPTH = 1 << DEPTH_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRIG  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef logic [NW-1:0][31:0] entry_t;

    state_t             r_state;
    logic [DEPTH_W-1:0] r_wr_ptr;
    logic [DEPTH_W-1:0] r_trig_ptr;
    logic [DEPTH_W-1:0] r_post_left;
    logic               r_wrapped;
    entry_t             r_mem [DEPTH];
    entry_t             r_rd_ent;
    logic [WSEL_W-1:0]  r_rd_wsel;
    logic               r_rd_v1;
    logic [31:0]        r_rd_data;
    logic               r_rd_valid;
`ifdef TLP_WIN_CAP_TS_EN
    logic [31:0]        r_ts;
`endif

    logic               w_active;
    logic               w_cap;
    logic               w_hit;
    logic [DEPTH_W-1:0] w_ptr_inc;
    entry_t             w_entry;
    logic [NSEL-1:0][31:0] w_words;

    assign w_active  = (r_state == S_ARMED) || (r_state == S_TRIG);
    assign w_cap     = st.st_valid && cfg_ch_en[st.st_ch] && w_active && !cfg_arm;
    assign w_hit     = w_cap && (r_state == S_ARMED) && st.st_sop &&
                       ((st.st_data[31:0] & cfg_trig_mask) == (cfg_trig_val & cfg_trig_mask));
    assign w_ptr_inc = r_wr_ptr + DEPTH_W'(1);

    // Word 0 is metadata; words 1..N hold data DWs, most-significant first.
    assign w_entry[0] = {st.st_sop, st.st_eop, st.st_ready, w_hit,
                         4'(st.st_ch), 8'h00, 16'(st.st_be)};
    for (genvar k = 1; k <= N; k++) begin : g_dw
        assign w_entry[k] = st.st_data[32*(N-k) +: 32];
    end
`ifdef TLP_WIN_CAP_TS_EN
    assign w_entry[N+1] = r_ts;
`endif

    always_comb begin
        w_words         = '0;
        w_words[NW-1:0] = r_rd_ent;
    end

    // Buffer and first read stage; same-cycle read of a written entry sees old data.
    always_ff @(posedge trn_clk) begin
        if (w_cap) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
        if (rd_en) begin
            r_rd_ent  <= r_mem[rd_addr[WSEL_W +: DEPTH_W]];
            r_rd_wsel <= rd_addr[WSEL_W-1:0];
        end
    end

    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_post_left <= '0;
            r_wrapped   <= 1'b0;
            r_rd_v1     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
`ifdef TLP_WIN_CAP_TS_EN
            r_ts        <= '0;
`endif
        end else begin
`ifdef TLP_WIN_CAP_TS_EN
            r_ts        <= r_ts + 32'd1;
`endif
            r_rd_v1    <= rd_en;
            r_rd_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_rd_data <= w_words[r_rd_wsel];
            end

            if (cfg_arm) begin
                r_state    <= S_ARMED;
                r_wr_ptr   <= '0;
                r_wrapped  <= 1'b0;
                r_trig_ptr <= '0;
            end else begin
                if (w_cap) begin
                    r_wr_ptr <= w_ptr_inc;
                    if (r_wr_ptr == '1) begin
                        r_wrapped <= 1'b1;
                    end
                end
                case (r_state)
                    S_ARMED: begin
                        if (w_hit) begin
                            r_trig_ptr  <= r_wr_ptr;
                            r_post_left <= cfg_post_cnt;
                            r_state     <= (cfg_post_cnt == '0 || cfg_stop) ? S_DONE : S_TRIG;
                        end else if (cfg_stop) begin
                            r_state    <= S_DONE;
                            r_trig_ptr <= w_cap ? w_ptr_inc : r_wr_ptr;
                        end
                    end
                    S_TRIG: begin
                        if (w_cap) begin
                            r_post_left <= r_post_left - DEPTH_W'(1);
                        end
                        if (cfg_stop) begin
                            r_state    <= S_DONE;
                            r_trig_ptr <= w_cap ? w_ptr_inc : r_wr_ptr;
                        end else if (w_cap && r_post_left == DEPTH_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cap_state    = r_state;
    assign cap_wr_ptr   = r_wr_ptr;
    assign cap_trig_ptr = r_trig_ptr;
    assign cap_wrapped  = r_wrapped;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
endmodule
